// File: rtl/fgp_rx_dma_pkg.sv
// rtl/fgp_rx_dma_pkg.sv - shared FGP receiver constants and state encoding
package fgp_rx_dma_pkg;

  localparam int BYTE_LEN       = 8;
  localparam int FGP_DATA_LEN   = 768;
  localparam int FGP_OFFSET_LEN = 1;

  // Packet parse phases: offset header, payload copy, discard until in_done
  typedef enum logic [1:0] {
    ST_OFFSET = 2'd0,
    ST_DATA   = 2'd1,
    ST_DRAIN  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/fgp_rx_dma_hdr.sv
// rtl/fgp_rx_dma_hdr.sv - big-endian offset assembly and range check for FGP packets
module fgp_rx_hdr
  import fgp_rx_dma_pkg::*;
#(
  parameter int OFFSET_BYTES = FGP_OFFSET_LEN,
  parameter int MAX_OFFSET   = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             byte_en,
  input  logic [BYTE_LEN-1:0]              byte_in,
  output logic                             hdr_ok,
  output logic                             hdr_bad,
  output logic [BYTE_LEN*OFFSET_BYTES-1:0] hdr_value
);

  localparam int          OW    = BYTE_LEN * OFFSET_BYTES;
  localparam int          BW    = $clog2(OFFSET_BYTES + 1);
  localparam logic [31:0] MAX_V = MAX_OFFSET;

  logic [BW-1:0] off_cnt;
  logic          last_byte;
  logic          in_range;

  // hdr_value is the offset including the byte arriving this cycle, so the
  // decision is available on the same edge that consumes the final byte.
  assign last_byte = byte_en && (off_cnt == BW'(OFFSET_BYTES - 1));
  assign in_range  = ({{(32 - OW){1'b0}}, hdr_value} <= MAX_V);
  assign hdr_ok    = last_byte && in_range;
  assign hdr_bad   = last_byte && !in_range;

  generate
    if (OFFSET_BYTES == 1) begin : g_one
      assign hdr_value = byte_in;
    end else begin : g_multi
      // Only the lower bytes are kept: the top byte shifts out on the next byte anyway.
      logic [OW-BYTE_LEN-1:0] off_acc;

      assign hdr_value = {off_acc, byte_in};

      // Shift each offset byte in, MSB first
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          off_acc <= '0;
        end else if (byte_en) begin
          off_acc <= hdr_value[OW-BYTE_LEN-1:0];
        end
      end
    end
  endgenerate

  // Count offset bytes; wraps to 0 after the last so the next packet starts clean
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      off_cnt <= '0;
    end else if (byte_en) begin
      off_cnt <= last_byte ? '0 : off_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fgp_rx_dma.sv
// rtl/fgp_rx_dma.sv - FGP packet receiver writing payload bytes straight into framebuffer RAM
module fgp_rx_dma
  import fgp_rx_dma_pkg::*;
#(
  parameter int OFFSET_BYTES = FGP_OFFSET_LEN,
  parameter int DATA_LEN     = FGP_DATA_LEN,
  parameter int MAX_OFFSET   = 255,
  parameter int ADDR_WIDTH   = 18
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             inclk,
  input  logic [BYTE_LEN-1:0]              in,
  input  logic                             in_done,
  output logic                             ram_we,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  output logic [BYTE_LEN-1:0]              ram_data,
  output logic                             offset_valid,
  output logic [BYTE_LEN*OFFSET_BYTES-1:0] offset_out,
  output logic                             done,
  output logic                             err
);

  localparam int                    OW       = BYTE_LEN * OFFSET_BYTES;
  localparam int                    CW       = $clog2(DATA_LEN + 1);
  localparam logic [ADDR_WIDTH-1:0] DLEN_A   = ADDR_WIDTH'(DATA_LEN);
  localparam logic [CW-1:0]         LAST_IDX = CW'(DATA_LEN - 1);

  rx_state_t             state;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] base;
  logic                  good_pending;
  logic                  err_pending;
  logic                  hdr_byte_en;
  logic                  hdr_ok;
  logic                  hdr_bad;
  logic [OW-1:0]         hdr_value;
  logic                  pkt_good;

  assign hdr_byte_en = inclk && (state == ST_OFFSET);

  // A packet is good at in_done only if exactly DATA_LEN bytes followed a legal
  // offset, counting a final data byte that lands on the same cycle as in_done.
  assign pkt_good = ((state == ST_DATA) && inclk && (cnt == LAST_IDX)) ||
                    ((state == ST_DRAIN) && good_pending && !err_pending && !inclk);

  fgp_rx_hdr #(
    .OFFSET_BYTES (OFFSET_BYTES),
    .MAX_OFFSET   (MAX_OFFSET)
  ) u_hdr (
    .clk       (clk),
    .rst       (rst),
    .clear     (in_done),
    .byte_en   (hdr_byte_en),
    .byte_in   (in),
    .hdr_ok    (hdr_ok),
    .hdr_bad   (hdr_bad),
    .hdr_value (hdr_value)
  );

  // Packet FSM, address generator and registered outputs; in_done overrides the byte step
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_OFFSET;
      cnt          <= '0;
      base         <= '0;
      good_pending <= 1'b0;
      err_pending  <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_data     <= '0;
      offset_valid <= 1'b0;
      offset_out   <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      ram_we       <= 1'b0;
      offset_valid <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;

      case (state)
        ST_OFFSET: begin
          if (hdr_ok) begin
            offset_out   <= hdr_value;
            offset_valid <= 1'b1;
            base         <= ADDR_WIDTH'(hdr_value) * DLEN_A;
            cnt          <= '0;
            state        <= ST_DATA;
          end else if (hdr_bad) begin
            err_pending  <= 1'b1;
            state        <= ST_DRAIN;
          end
        end
        ST_DATA: begin
          if (inclk) begin
            ram_we   <= 1'b1;
            ram_addr <= base + ADDR_WIDTH'(cnt);
            ram_data <= in;
            if (cnt == LAST_IDX) begin
              good_pending <= 1'b1;
              state        <= ST_DRAIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (inclk && good_pending) begin
            good_pending <= 1'b0;
            err_pending  <= 1'b1;
          end
        end
        default: state <= ST_OFFSET;
      endcase

      if (in_done) begin
        done         <= pkt_good;
        err          <= !pkt_good;
        state        <= ST_OFFSET;
        cnt          <= '0;
        good_pending <= 1'b0;
        err_pending  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fgp_rx_dma.sv
// tb/tb_fgp_rx_dma.sv - directed bench for fgp_rx_dma with a packet-level reference model
module tb_fgp_rx_dma;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0 = 1'b0, inclk0 = 1'b0, in_done0 = 1'b0;
  logic [7:0]  in0 = 8'd0;
  logic        ram_we0, ov0, done0, err0;
  logic [17:0] ram_addr0;
  logic [7:0]  ram_data0, oo0;

  logic        rst1 = 1'b0, inclk1 = 1'b0, in_done1 = 1'b0;
  logic [7:0]  in1 = 8'd0;
  logic        ram_we1, ov1, done1, err1;
  logic [17:0] ram_addr1;
  logic [7:0]  ram_data1;
  logic [15:0] oo1;

  fgp_rx_dma dut0 (
    .clk(clk), .rst(rst0), .inclk(inclk0), .in(in0), .in_done(in_done0),
    .ram_we(ram_we0), .ram_addr(ram_addr0), .ram_data(ram_data0),
    .offset_valid(ov0), .offset_out(oo0), .done(done0), .err(err0)
  );

  fgp_rx_dma #(.OFFSET_BYTES(2), .DATA_LEN(768), .MAX_OFFSET(300), .ADDR_WIDTH(18)) dut1 (
    .clk(clk), .rst(rst1), .inclk(inclk1), .in(in1), .in_done(in_done1),
    .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_data(ram_data1),
    .offset_valid(ov1), .offset_out(oo1), .done(done1), .err(err1)
  );

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  started = 1'b0;

  int  pos [2];
  int  offv [2];
  int  base_m [2];
  bit  bad [2];
  bit  e_we [2], e_ov [2], e_done [2], e_err [2];
  int  e_addr [2], e_data [2], e_oo [2];

  int  wr_cnt [2], first_addr [2], last_addr [2], done_cnt [2], err_cnt [2], ov_cnt [2];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: position of a byte inside the packet decides what it must do
  task automatic model(input int d, input bit r, input bit ic, input logic [7:0] b, input bit dn);
    int ob, mx;
    bit good;
    ob = (d == 1) ? 2 : 1;
    mx = (d == 1) ? 300 : 255;
    e_we[d] = 0; e_ov[d] = 0; e_done[d] = 0; e_err[d] = 0;
    if (r) begin
      pos[d] = 0; offv[d] = 0; bad[d] = 0; e_oo[d] = 0; e_addr[d] = 0; e_data[d] = 0;
      return;
    end
    if (ic) begin
      if (pos[d] < ob) begin
        offv[d] = (offv[d] << 8) | int'(b);
        if (pos[d] == ob - 1) begin
          if (offv[d] <= mx) begin
            e_ov[d] = 1; e_oo[d] = offv[d]; base_m[d] = offv[d] * 768;
          end else begin
            bad[d] = 1;
          end
        end
      end else if (!bad[d]) begin
        if (pos[d] - ob < 768) begin
          e_we[d] = 1; e_addr[d] = base_m[d] + pos[d] - ob; e_data[d] = int'(b);
        end else begin
          bad[d] = 1;
        end
      end
      pos[d]++;
    end
    if (dn) begin
      good = !bad[d] && (pos[d] == ob + 768);
      e_done[d] = good; e_err[d] = !good;
      pos[d] = 0; offv[d] = 0; bad[d] = 0;
    end
  endtask

  task automatic cmp_dut(input int d, input logic we, input logic [17:0] a, input logic [7:0] dat,
                         input logic ov, input logic [15:0] oo, input logic dn, input logic er);
    chk($sformatf("d%0d_ram_we", d), we, e_we[d]);
    if (e_we[d]) begin
      chk($sformatf("d%0d_ram_addr", d), a, e_addr[d]);
      chk($sformatf("d%0d_ram_data", d), dat, e_data[d]);
    end
    chk($sformatf("d%0d_offset_valid", d), ov, e_ov[d]);
    chk($sformatf("d%0d_offset_out", d), oo, e_oo[d]);
    chk($sformatf("d%0d_done", d), dn, e_done[d]);
    chk($sformatf("d%0d_err", d), er, e_err[d]);
    if (we === 1'b1) begin
      if (wr_cnt[d] == 0) first_addr[d] = int'(a);
      last_addr[d] = int'(a);
      wr_cnt[d]++;
    end
    if (dn === 1'b1) done_cnt[d]++;
    if (er === 1'b1) err_cnt[d]++;
    if (ov === 1'b1) ov_cnt[d]++;
  endtask

  // Every cycle, after outputs settle, check both DUTs against the model
  always @(posedge clk) begin
    #1;
    if (started) begin
      cmp_dut(0, ram_we0, ram_addr0, ram_data0, ov0, {8'd0, oo0}, done0, err0);
      cmp_dut(1, ram_we1, ram_addr1, ram_data1, ov1, oo1, done1, err1);
    end
  end

  // d selects the DUT driven (2 = both); the other one idles
  task automatic step(input int d, input bit r, input bit ic, input logic [7:0] b, input bit dn);
    bit s0, s1;
    @(negedge clk);
    s0 = (d == 0) || (d == 2);
    s1 = (d == 1) || (d == 2);
    rst0 = s0 && r; inclk0 = s0 && ic; in0 = s0 ? b : 8'd0; in_done0 = s0 && dn;
    rst1 = s1 && r; inclk1 = s1 && ic; in1 = s1 ? b : 8'd0; in_done1 = s1 && dn;
    model(0, rst0, inclk0, in0, in_done0);
    model(1, rst1, inclk1, in1, in_done1);
    started = 1'b1;
  endtask

  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      wr_cnt[d] = 0; first_addr[d] = -1; last_addr[d] = -1;
      done_cnt[d] = 0; err_cnt[d] = 0; ov_cnt[d] = 0;
    end
  endtask

  task automatic send(input int d, input int off, input int nbytes, input bit done_last);
    int ob;
    ob = (d == 1) ? 2 : 1;
    for (int k = ob - 1; k >= 0; k--)
      step(d, 0, 1, 8'(off >> (8 * k)), (nbytes == 0) && (k == 0) && done_last);
    for (int i = 0; i < nbytes; i++)
      step(d, 0, 1, 8'(i), done_last && (i == nbytes - 1));
    if (!done_last) step(d, 0, 0, 8'd0, 1);
    step(d, 0, 0, 8'd0, 0);
    step(d, 0, 0, 8'd0, 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      pos[d] = 0; offv[d] = 0; base_m[d] = 0; bad[d] = 0;
      e_we[d] = 0; e_ov[d] = 0; e_done[d] = 0; e_err[d] = 0;
      e_addr[d] = 0; e_data[d] = 0; e_oo[d] = 0;
    end
    clear_stats();

    step(2, 1, 0, 8'd0, 0);
    step(2, 1, 0, 8'd0, 0);
    step(2, 0, 0, 8'd0, 0);
    chk("rst_ram_addr0", ram_addr0, 0);
    chk("rst_ram_we1", ram_we1, 0);
    chk("rst_offset_out1", oo1, 0);

    clear_stats();
    send(0, 2, 768, 0);
    chk("good_writes", wr_cnt[0], 768);
    chk("good_first_addr", first_addr[0], 1536);
    chk("good_last_addr", last_addr[0], 2303);
    chk("good_done", done_cnt[0], 1);
    chk("good_err", err_cnt[0], 0);
    chk("good_offset_out", oo0, 2);

    clear_stats();
    send(0, 3, 768, 1);
    chk("same_cycle_writes", wr_cnt[0], 768);
    chk("same_cycle_first", first_addr[0], 2304);
    chk("same_cycle_done", done_cnt[0], 1);
    chk("same_cycle_err", err_cnt[0], 0);

    clear_stats();
    send(0, 5, 100, 0);
    chk("short_writes", wr_cnt[0], 100);
    chk("short_first", first_addr[0], 3840);
    chk("short_err", err_cnt[0], 1);
    chk("short_done", done_cnt[0], 0);

    clear_stats();
    send(0, 7, 770, 0);
    chk("long_writes", wr_cnt[0], 768);
    chk("long_err", err_cnt[0], 1);
    chk("long_done", done_cnt[0], 0);

    clear_stats();
    step(0, 0, 0, 8'd0, 1);
    step(0, 0, 0, 8'd0, 0);
    step(0, 0, 0, 8'd0, 0);
    chk("empty_err", err_cnt[0], 1);
    chk("empty_done", done_cnt[0], 0);

    clear_stats();
    send(1, 'h12D, 768, 0);
    chk("range_writes", wr_cnt[1], 0);
    chk("range_err", err_cnt[1], 1);
    chk("range_offset_valid", ov_cnt[1], 0);
    chk("range_offset_out", oo1, 0);

    clear_stats();
    send(1, 'h12C, 768, 0);
    chk("max_first", first_addr[1], 230400);
    chk("max_last", last_addr[1], 231167);
    chk("max_done", done_cnt[1], 1);
    chk("max_offset_out", oo1, 'h12C);

    step(0, 0, 1, 8'd4, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 8'(i), 0);
    step(0, 1, 0, 8'd0, 0);
    step(0, 0, 0, 8'd0, 0);
    chk("abandon_we", ram_we0, 0);
    clear_stats();
    send(0, 1, 768, 0);
    chk("after_rst_writes", wr_cnt[0], 768);
    chk("after_rst_first", first_addr[0], 768);
    chk("after_rst_done", done_cnt[0], 1);
    chk("after_rst_err", err_cnt[0], 0);

    step(2, 0, 0, 8'd0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
